// File: rtl/mac_pkg.sv
// Shared definitions for the sequential Booth multiply-accumulate unit:
// FSM state encoding, Booth pair codes and default widths.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ACC  = 2'd2
    } state_t;

    // {Q[0], q_-1} codes that modify the partial accumulator
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_ACC_WIDTH = 2 * DEF_WIDTH + 8;

endpackage

// File: rtl/mac_booth_seq_if.sv
// Operand/result bundle of the multiply-accumulate unit.
// master: the requester driving start and operands; slave: the MAC itself.
interface mac_booth_seq_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 2 * WIDTH + 8
);
    logic                          start;
    logic                          acc_clear;
    logic signed [WIDTH-1:0]       multiplicand;
    logic signed [WIDTH-1:0]       multiplier;
    logic                          busy;
    logic                          done;
    logic signed [2*WIDTH-1:0]     product;
    logic signed [ACC_WIDTH-1:0]   acc_out;
    logic                          overflow;

    modport master (
        output start, acc_clear, multiplicand, multiplier,
        input  busy, done, product, acc_out, overflow
    );

    modport slave (
        input  start, acc_clear, multiplicand, multiplier,
        output busy, done, product, acc_out, overflow
    );
endinterface

// File: rtl/mac_booth_core.sv
// Radix-2 Booth multiplier datapath. The owner loads operands and then
// issues WIDTH step strobes; the product is read from the partial register.
module mac_booth_core
    import mac_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic                      i_load,
    input  logic                      i_step,
    input  logic signed [WIDTH-1:0]   i_multiplicand,
    input  logic signed [WIDTH-1:0]   i_multiplier,
    output logic signed [2*WIDTH-1:0] o_product
);
    // A carries one extra bit so that subtracting -2^(WIDTH-1) cannot wrap
    logic signed [WIDTH:0]   r_a;
    logic signed [WIDTH-1:0] r_q;
    logic                    r_qm1;
    logic signed [WIDTH-1:0] r_m;

    logic signed [WIDTH:0]   w_m_ext;
    logic signed [WIDTH:0]   w_a_sum;
    logic [1:0]              w_pair;

    assign w_m_ext = (WIDTH+1)'(r_m);
    assign w_pair  = {r_q[0], r_qm1};

    // Add, subtract or keep the multiplicand depending on the Booth pair
    always_comb begin
        w_a_sum = r_a;
        case (w_pair)
            BOOTH_ADD: w_a_sum = r_a + w_m_ext;
            BOOTH_SUB: w_a_sum = r_a - w_m_ext;
            default:   w_a_sum = r_a;
        endcase
    end

    // Operand load, then add/subtract followed by arithmetic shift of {A,Q,q-1}
    always_ff @(posedge clock) begin
        if (clear) begin
            r_a   <= '0;
            r_q   <= '0;
            r_qm1 <= 1'b0;
            r_m   <= '0;
        end else if (i_load) begin
            r_a   <= '0;
            r_q   <= i_multiplier;
            r_qm1 <= 1'b0;
            r_m   <= i_multiplicand;
        end else if (i_step) begin
            r_a   <= {w_a_sum[WIDTH], w_a_sum[WIDTH:1]};
            r_q   <= {w_a_sum[0], r_q[WIDTH-1:1]};
            r_qm1 <= r_q[0];
        end
    end

    assign o_product = {r_a[WIDTH-1:0], r_q};

endmodule

// File: rtl/mac_booth_seq.sv
// Sequential signed multiply-accumulate: Booth core plus a sign-extended
// accumulator with sticky overflow.
// Optional macro SATURATE_EN: clamp the accumulator on overflow instead of
// wrapping modulo 2^ACC_WIDTH.
module mac_booth_seq
    import mac_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = 2 * WIDTH + 8
) (
    input  logic            clock,
    input  logic            clear,
    mac_booth_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t                        r_state;
    logic [CNT_W-1:0]              r_cnt;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_ovf;
    logic                          r_acc_clr;
    logic signed [2*WIDTH-1:0]     r_product;
    logic signed [ACC_WIDTH-1:0]   r_acc;

    logic                          w_load;
    logic                          w_step;
    logic signed [2*WIDTH-1:0]     w_product;
    logic signed [ACC_WIDTH-1:0]   w_prod_ext;
    logic signed [ACC_WIDTH-1:0]   w_base;
    logic signed [ACC_WIDTH-1:0]   w_sum;
    logic signed [ACC_WIDTH-1:0]   w_acc_next;
    logic                          w_ovf;

    assign w_load = (r_state == IDLE) && bus.start;
    assign w_step = (r_state == RUN);

    mac_booth_core #(.WIDTH(WIDTH)) u_core (
        .clock          (clock),
        .clear          (clear),
        .i_load         (w_load),
        .i_step         (w_step),
        .i_multiplicand (bus.multiplicand),
        .i_multiplier   (bus.multiplier),
        .o_product      (w_product)
    );

    // Accumulate: equal addend signs with a differing result sign is overflow
    assign w_prod_ext = ACC_WIDTH'(w_product);
    assign w_base     = r_acc_clr ? '0 : r_acc;
    assign w_sum      = w_base + w_prod_ext;
    assign w_ovf      = (w_base[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1]) &&
                        (w_sum[ACC_WIDTH-1]  != w_base[ACC_WIDTH-1]);

`ifdef SATURATE_EN
    function automatic logic signed [ACC_WIDTH-1:0] sat_acc(
        input logic signed [ACC_WIDTH-1:0] sum,
        input logic                        ovf,
        input logic                        neg
    );
        if (!ovf)
            return sum;
        else if (neg)
            return {1'b1, {(ACC_WIDTH-1){1'b0}}};
        else
            return {1'b0, {(ACC_WIDTH-1){1'b1}}};
    endfunction

    assign w_acc_next = sat_acc(w_sum, w_ovf, w_prod_ext[ACC_WIDTH-1]);
`else
    assign w_acc_next = w_sum;
`endif

    // Control FSM: accept, run WIDTH Booth steps, then accumulate and pulse done
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_acc_clr <= 1'b0;
            r_product <= '0;
            r_acc     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_acc_clr <= bus.acc_clear;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= RUN;
                        if (bus.acc_clear)
                            r_ovf <= 1'b0;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1))
                        r_state <= ACC;
                end
                ACC: begin
                    r_product <= w_product;
                    r_acc     <= w_acc_next;
                    if (w_ovf)
                        r_ovf <= 1'b1;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.product  = r_product;
    assign bus.acc_out  = r_acc;
    assign bus.overflow = r_ovf;

endmodule
